// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU package: register-file geometry and the memory-port arbiter state encoding.
package pipe_hazard_ctrl_pkg;

  // Register-specifier width: 16 GPRs, R0 hardwired to zero.
  localparam int unsigned REG_W = 4;

  // Default width of the stall-cycle performance counter.
  localparam int unsigned STALL_CNT_W = 32;

  // Ownership state of the shared main-memory port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_D = 2'd1,
    FILL_I = 2'd2
  } arb_state_e;

  // Pipeline-register control bundle produced by the hazard unit.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_bubble;
  } pipe_ctrl_t;

  // True when a source operand is actually read and names the given destination.
  function automatic logic src_hit(input logic used, input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard-controller bundle: operand specifiers, cache misses, memory port, controls.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_W = pipe_hazard_ctrl_pkg::REG_W,
  parameter int unsigned CNT_W = pipe_hazard_ctrl_pkg::STALL_CNT_W
);

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             id_mispredict;
  logic             icache_miss;
  logic             dcache_miss;
  logic             mem_ready;

  logic             mem_grant_i;
  logic             mem_grant_d;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_bubble;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: supplies hazard sources, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_read, ex_rd,
           id_mispredict, icache_miss, dcache_miss, mem_ready,
    input  mem_grant_i, mem_grant_d, pc_stall, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_read, ex_rd,
           id_mispredict, icache_miss, dcache_miss, mem_ready,
    output mem_grant_i, mem_grant_d, pc_stall, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_arbiter.sv
// Shared main-memory port arbiter: D-side wins ties, a granted fill is never preempted.
module mem_port_arbiter
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dcache_miss,
  input  logic       icache_miss,
  input  logic       mem_ready,
  output arb_state_e state,
  output logic       grant_d,
  output logic       grant_i
);

  arb_state_e state_next;

  // State and grant registers; grants decode the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant_d <= 1'b0;
      grant_i <= 1'b0;
    end else begin
      state   <= state_next;
      grant_d <= (state_next == FILL_D);
      grant_i <= (state_next == FILL_I);
    end
  end

  // Next-state: mem_ready only matters while a fill is outstanding.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (dcache_miss)      state_next = FILL_D;
        else if (icache_miss) state_next = FILL_I;
      end
      FILL_D: begin
        if (mem_ready) state_next = icache_miss ? FILL_I : IDLE;
      end
      FILL_I: begin
        if (mem_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush generation plus stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = pipe_hazard_ctrl_pkg::REG_W,
  parameter int unsigned CNT_W = pipe_hazard_ctrl_pkg::STALL_CNT_W
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  arb_state_e       arb_state;
  logic             grant_d;
  logic             grant_i;
  logic             dstall;
  logic             istall;
  logic             load_use;
  logic [REG_W-1:0] ex_rd;
  pipe_ctrl_t       ctrl;
  logic [CNT_W-1:0] stall_cnt;

  mem_port_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .dcache_miss (bus.dcache_miss),
    .icache_miss (bus.icache_miss),
    .mem_ready   (bus.mem_ready),
    .state       (arb_state),
    .grant_d     (grant_d),
    .grant_i     (grant_i)
  );

  assign ex_rd = bus.ex_rd;

  // Stall causes; a fill keeps stalling after the cache drops its miss flag.
  assign dstall   = bus.dcache_miss || (arb_state == FILL_D);
  assign istall   = bus.icache_miss || (arb_state == FILL_I);
  assign load_use = bus.ex_mem_read && (ex_rd != REG_W'(0)) &&
                    (src_hit(bus.id_rs1_used, bus.id_rs1, ex_rd) ||
                     src_hit(bus.id_rs2_used, bus.id_rs2, ex_rd));

  // Priority dstall > load_use > mispredict > istall; load_use defers the branch a cycle.
  always_comb begin
    ctrl = '0;
    if (dstall) begin
      ctrl.pc_stall      = 1'b1;
      ctrl.if_id_stall   = 1'b1;
      ctrl.id_ex_stall   = 1'b1;
      ctrl.ex_mem_stall  = 1'b1;
      ctrl.mem_wb_bubble = 1'b1;
    end else if (load_use) begin
      ctrl.pc_stall      = 1'b1;
      ctrl.if_id_stall   = 1'b1;
      ctrl.id_ex_flush   = 1'b1;
    end else if (bus.id_mispredict) begin
      ctrl.if_id_flush   = 1'b1;
    end else if (istall) begin
      ctrl.pc_stall      = 1'b1;
      ctrl.if_id_flush   = 1'b1;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (ctrl.pc_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.mem_grant_d   = grant_d;
  assign bus.mem_grant_i   = grant_i;
  assign bus.pc_stall      = ctrl.pc_stall;
  assign bus.if_id_stall   = ctrl.if_id_stall;
  assign bus.if_id_flush   = ctrl.if_id_flush;
  assign bus.id_ex_stall   = ctrl.id_ex_stall;
  assign bus.id_ex_flush   = ctrl.id_ex_flush;
  assign bus.ex_mem_stall  = ctrl.ex_mem_stall;
  assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
  assign bus.stall_cycles  = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with a 4-bit counter shares the stimulus.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // Control vector order: pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_DSTALL = 7'b1101011;
  localparam logic [6:0] C_LU     = 7'b1100100;
  localparam logic [6:0] C_MISP   = 7'b0010000;
  localparam logic [6:0] C_ISTALL = 7'b1010000;
  // Grant vector order: {mem_grant_i, mem_grant_d}
  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_D    = 2'b01;
  localparam logic [1:0] G_I    = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(32)) bus ();
  pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(4))  bus4 ();

  assign bus4.id_rs1        = bus.id_rs1;
  assign bus4.id_rs2        = bus.id_rs2;
  assign bus4.id_rs1_used   = bus.id_rs1_used;
  assign bus4.id_rs2_used   = bus.id_rs2_used;
  assign bus4.ex_mem_read   = bus.ex_mem_read;
  assign bus4.ex_rd         = bus.ex_rd;
  assign bus4.id_mispredict = bus.id_mispredict;
  assign bus4.icache_miss   = bus.icache_miss;
  assign bus4.dcache_miss   = bus.dcache_miss;
  assign bus4.mem_ready     = bus.mem_ready;

  pipe_hazard_ctrl #(.REG_W(4), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  pipe_hazard_ctrl #(.REG_W(4), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [6:0] ctrl_of();
    return {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
            bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_bubble};
  endfunction

  function automatic logic [1:0] grants();
    return {bus.mem_grant_i, bus.mem_grant_d};
  endfunction

  task automatic clear_inputs();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_rd = '0; bus.id_mispredict = 1'b0;
    bus.icache_miss = 1'b0; bus.dcache_miss = 1'b0; bus.mem_ready = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs checked #1 later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [3:0] rd, input logic [3:0] rs1, input logic u1,
                              input logic [3:0] rs2, input logic u2);
    bus.ex_mem_read = 1'b1; bus.ex_rd = rd;
    bus.id_rs1 = rs1; bus.id_rs1_used = u1;
    bus.id_rs2 = rs2; bus.id_rs2_used = u2;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    #1 rst = 1'b1;
    #1;
    check("reset_grants", 32'(grants()), 32'(G_NONE));
    check("reset_cnt", bus.stall_cycles, 32'd0);
    check("reset_ctrl", 32'(ctrl_of()), 32'(C_NONE));
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;

    // Quiet pipeline
    next_cycle(); #1;
    check("idle_ctrl", 32'(ctrl_of()), 32'(C_NONE));
    check("idle_cnt", bus.stall_cycles, 32'd0);

    // Load-use on rs1 for one cycle
    next_cycle(); set_load_use(4'd3, 4'd3, 1'b1, 4'd0, 1'b0); #1;
    check("lu_rs1_ctrl", 32'(ctrl_of()), 32'(C_LU));
    next_cycle(); clear_inputs(); #1;
    check("lu_rs1_after_ctrl", 32'(ctrl_of()), 32'(C_NONE));
    check("lu_rs1_cnt", bus.stall_cycles, 32'd1);

    // Load-use on rs2 only
    set_load_use(4'd5, 4'd7, 1'b1, 4'd5, 1'b1); #1;
    check("lu_rs2_ctrl", 32'(ctrl_of()), 32'(C_LU));
    next_cycle(); clear_inputs();
    // Matching specifier that is not read
    set_load_use(4'd6, 4'd6, 1'b0, 4'd6, 1'b0); #1;
    check("lu_unused_ctrl", 32'(ctrl_of()), 32'(C_NONE));
    check("lu_rs2_cnt", bus.stall_cycles, 32'd2);

    // Load to R0 never stalls
    next_cycle(); clear_inputs(); set_load_use(4'd0, 4'd0, 1'b1, 4'd0, 1'b1); #1;
    check("lu_r0_ctrl", 32'(ctrl_of()), 32'(C_NONE));

    // Mispredict alone, then masked by load-use
    next_cycle(); clear_inputs(); bus.id_mispredict = 1'b1; #1;
    check("misp_ctrl", 32'(ctrl_of()), 32'(C_MISP));
    next_cycle(); set_load_use(4'd9, 4'd9, 1'b1, 4'd0, 1'b0); #1;
    check("lu_masks_misp", 32'(ctrl_of()), 32'(C_LU));

    // Cycle 0: both misses plus load-use and mispredict; D-side wins everything
    next_cycle(); bus.dcache_miss = 1'b1; bus.icache_miss = 1'b1; #1;
    check("dstall_prio_ctrl", 32'(ctrl_of()), 32'(C_DSTALL));
    check("dstall_prio_grants", 32'(grants()), 32'(G_NONE));
    check("pre_fill_cnt", bus.stall_cycles, 32'd3);
    // Cycle 1: FILL_D; icache miss still pending
    next_cycle(); clear_inputs(); bus.icache_miss = 1'b1; #1;
    check("fill_d_grants", 32'(grants()), 32'(G_D));
    check("fill_d_ctrl", 32'(ctrl_of()), 32'(C_DSTALL));
    repeat (3) next_cycle();
    // Cycle 4: fill not yet complete
    #1 check("fill_d_hold_grants", 32'(grants()), 32'(G_D));
    // Cycle 5: memory completes the D fill
    next_cycle(); bus.mem_ready = 1'b1;
    // Cycle 6: I fill takes the port
    next_cycle(); bus.mem_ready = 1'b0; #1;
    check("fill_i_grants", 32'(grants()), 32'(G_I));
    check("fill_i_ctrl", 32'(ctrl_of()), 32'(C_ISTALL));
    // Cycle 7: a new D miss cannot preempt the I fill
    next_cycle(); bus.dcache_miss = 1'b1; #1;
    check("no_preempt_ctrl", 32'(ctrl_of()), 32'(C_DSTALL));
    // Cycle 8
    next_cycle(); bus.dcache_miss = 1'b0; #1;
    check("no_preempt_grants", 32'(grants()), 32'(G_I));
    // Cycle 9: I fill complete, cache flag already dropped but fill still stalls
    next_cycle(); bus.icache_miss = 1'b0; bus.mem_ready = 1'b1; #1;
    check("fill_i_last_ctrl", 32'(ctrl_of()), 32'(C_ISTALL));
    // Cycle 10: back to IDLE; stray mem_ready must be ignored
    next_cycle(); bus.mem_ready = 1'b1; #1;
    check("fill_done_grants", 32'(grants()), 32'(G_NONE));
    check("fill_done_ctrl", 32'(ctrl_of()), 32'(C_NONE));
    check("fill_done_cnt", bus.stall_cycles, 32'd13);
    next_cycle(); bus.mem_ready = 1'b0; #1;
    check("idle_ready_ignored", 32'(grants()), 32'(G_NONE));

    // Reset during an I fill
    next_cycle(); bus.icache_miss = 1'b1;
    next_cycle(); bus.icache_miss = 1'b0; #1;
    check("rst_fill_i_grants", 32'(grants()), 32'(G_I));
    next_cycle(); next_cycle();
    #1 rst = 1'b1;
    #1;
    check("rst_mid_grants", 32'(grants()), 32'(G_NONE));
    check("rst_mid_cnt", bus.stall_cycles, 32'd0);
    check("rst_mid_cnt4", 32'(bus4.stall_cycles), 32'd0);
    check("rst_mid_ctrl", 32'(ctrl_of()), 32'(C_NONE));
    #2 rst = 1'b0;
    next_cycle(); bus.mem_ready = 1'b1;
    next_cycle(); bus.mem_ready = 1'b0; #1;
    check("rst_ready_ignored", 32'(grants()), 32'(G_NONE));
    check("rst_ready_ctrl", 32'(ctrl_of()), 32'(C_NONE));

    // 20 cycles of continuous pc_stall: 4-bit counter saturates at 15
    set_load_use(4'd2, 4'd2, 1'b1, 4'd0, 1'b0);
    repeat (14) next_cycle();
    #1;
    check("sat_cnt4_14", 32'(bus4.stall_cycles), 32'd14);
    repeat (6) next_cycle();
    #1;
    check("sat_cnt4_hold", 32'(bus4.stall_cycles), 32'd15);
    check("sat_cnt32_20", bus.stall_cycles, 32'd20);
    clear_inputs();
    next_cycle(); #1;
    check("sat_cnt4_after", 32'(bus4.stall_cycles), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
